// File: rtl/pbkdf2_ctrl_pkg.sv
// PBKDF2 controller shared types.
// State encoding, HMAC operand widths, mode codes.
package pbkdf2_ctrl_pkg;

  localparam int KEY_W = 1024;
  localparam int MSG_W = 512;
  localparam int DIG_W = 512;

  localparam logic MODE_SALT = 1'b0;
  localparam logic MODE_DIG  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_e;

endpackage

// File: rtl/pbkdf2_ctrl.sv
// PBKDF2 round sequencer driving an external HMAC core.
// Optional PBKDF2_ABORT_EN adds an abort input.
module pbkdf2_ctrl
  import pbkdf2_ctrl_pkg::*;
#(
  parameter int ITER_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic [KEY_W-1:0]  key,
  input  logic [MSG_W-1:0]  salt_msg,
`ifdef PBKDF2_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [DIG_W-1:0]  dk,
  output logic              hmac_reset,
  output logic              hmac_mode,
  output logic [KEY_W-1:0]  hmac_key,
  output logic [MSG_W-1:0]  hmac_msg,
  input  logic              hmac_done,
  input  logic [DIG_W-1:0]  hmac_oH
);

  state_e              state_q;
  logic [ITER_W-1:0]   cnt_q;
  logic [ITER_W-1:0]   lim_q;
  logic [KEY_W-1:0]    key_q;
  logic [MSG_W-1:0]    msg_q;
  logic                mode_q;
  logic [DIG_W-1:0]    t_q;
  logic [DIG_W-1:0]    t_d;
  logic [DIG_W-1:0]    dk_q;
  logic                busy_q;
  logic                done_q;
  logic                hrst_q;
  logic                first_q;
  logic                kill;

  assign busy       = busy_q;
  assign done       = done_q;
  assign dk         = dk_q;
  assign hmac_reset = hrst_q;
  assign hmac_mode  = mode_q;
  assign hmac_key   = key_q;
  assign hmac_msg   = msg_q;

`ifdef PBKDF2_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // First round seeds T, later rounds accumulate.
  always_comb begin
    t_d = t_q ^ hmac_oH;
    if (cnt_q == ITER_W'(1)) t_d = hmac_oH;
  end

  // Round sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      mode_q  <= MODE_SALT;
      t_q     <= '0;
      dk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hrst_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          hrst_q <= 1'b1;
          busy_q <= 1'b0;
          if (start) begin
            key_q   <= key;
            msg_q   <= salt_msg;
            mode_q  <= MODE_SALT;
            lim_q   <= (iters == '0) ? ITER_W'(1)
                                     : iters;
            cnt_q   <= ITER_W'(1);
            t_q     <= '0;
            busy_q  <= 1'b1;
            hrst_q  <= 1'b0;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          hrst_q  <= 1'b1;
          first_q <= 1'b1;
          state_q <= S_WAIT;
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          first_q <= 1'b0;
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!first_q && hmac_done) begin
            t_q    <= t_d;
            msg_q  <= hmac_oH;
            mode_q <= MODE_DIG;
            if (cnt_q == lim_q) begin
              dk_q    <= t_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              cnt_q   <= cnt_q + ITER_W'(1);
              hrst_q  <= 1'b0;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pbkdf2_ctrl.md
PBKDF2_CTRL -- requirements
Module: pbkdf2_ctrl

Interface
REQ-001 SHALL have parameter ITER_W, default 32, width of the iteration count.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a derivation; sampled only in IDLE.
REQ-005 SHALL have port iters  input  ITER_W  PBKDF2 iteration count c.
REQ-006 SHALL have port key  input  1024  HMAC key (password), pre-formatted for hmac.
REQ-007 SHALL have port salt_msg  input  512  first-round message (salt || INT(i)), pre-formatted.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; dk valid from this cycle until the next accepted start.
REQ-010 SHALL have port dk  output  512  derived block T = U1 ^ U2 ^ ... ^ Uc.
REQ-011 SHALL have port hmac_reset  output  1  active-low run/restart to downstream hmac.
REQ-012 SHALL have port hmac_mode  output  1  0 on round 1 (salt message), 1 on rounds 2..c (digest message).
REQ-013 SHALL have ports hmac_key (output 1024) and hmac_msg (output 512): operands to hmac.
REQ-014 SHALL have ports hmac_done (input 1) and hmac_oH (input 512): completion flag and digest from hmac.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT, FINISH.
REQ-016 IDLE: on start=1, SHALL capture key, salt_msg and iters; set round counter to 1; go to LAUNCH.
REQ-017 iters=0 SHALL be treated as iters=1.
REQ-018 LAUNCH: SHALL drive hmac_reset=0 for exactly one cycle with hmac_key, hmac_msg and hmac_mode stable; then go to WAIT.
REQ-019 WAIT: SHALL drive hmac_reset=1 and hold operands stable; hmac_done SHALL be ignored in the first WAIT cycle (stale flag).
REQ-020 On hmac_done=1 in round 1, SHALL load T with hmac_oH; in later rounds SHALL load T with T ^ hmac_oH.
REQ-021 In that same cycle, SHALL load hmac_msg with hmac_oH and set hmac_mode=1.
REQ-022 In that same cycle, if the round counter equals the effective iters, SHALL go to FINISH; otherwise SHALL increment the counter and go to LAUNCH.
REQ-023 FINISH: SHALL pulse done for one cycle with dk=T, keep hmac_reset=1, and return to IDLE.
REQ-024 Per-round overhead beyond hmac latency SHALL be exactly 2 cycles (LAUNCH plus first WAIT cycle).
REQ-025 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-026 hmac_done outside WAIT SHALL be ignored.
REQ-027 The round counter SHALL be ITER_W bits and SHALL never wrap, because the terminal compare precedes the increment.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE and set busy=0, done=0, dk=0, T=0, counter=0, hmac_mode=0, hmac_key=0, hmac_msg=0, hmac_reset=0.
REQ-029 In IDLE after reset release, hmac_reset SHALL be driven 1.
REQ-030 Reset mid-derivation SHALL discard all partial state; no done pulse SHALL follow.

Configuration
REQ-031 With macro PBKDF2_ABORT_EN defined, SHALL add input abort (1 bit): abort=1 in LAUNCH or WAIT returns to IDLE next cycle, with busy=0, no done pulse and dk unchanged.
REQ-032 Without PBKDF2_ABORT_EN, SHALL have no abort port and no abort logic.

Structure
REQ-033 A shared package SHALL hold the state enum, the HMAC block widths (KEY_W=1024, MSG_W=512, DIG_W=512) and the mode encodings.
REQ-034 SHALL be a single module with no sub-modules; the hmac instance SHALL reside in the parent.

Verification
REQ-035 Bench SHALL use a behavioural hmac stub with done after 10 cycles and oH=msg+1. Case: iters=1, salt_msg=0 -> one done pulse, dk=1, exactly one LAUNCH.
REQ-036 Stub, iters=3, salt_msg=0 -> U=1,2,3 and dk=1^2^3=0; hmac_mode sequence 0,1,1; done at cycle 3*(10+2)+2 after start.
REQ-037 Stub, iters=0 -> same result as iters=1; start pulsed during busy -> ignored, single done.
REQ-038 Stub, reset=0 asserted in WAIT of round 2 -> immediate IDLE, all outputs 0, no done; a new start then completes normally.
REQ-039 Real hmac, key="password", salt="salt"||INT(1), iters=1 -> dk=867f70cf1ade02cff3752599a3a53dc4af34c7a669815ae5d513554e1c8cf252c02d470a285a0501bad999bfe943c08f050235d7d68b1da55e63f73b60a57fce.
REQ-040 Under PBKDF2_ABORT_EN, stub, iters=5, abort in round 3 -> IDLE next cycle, no done, dk retains previous value.
